// File: rtl/uss_gather.sv
// uss_gather: walks the 4x4 neighbour window selected by the USS mask.
// For each in-image neighbour it reads the 8x8 pixel buffer and sums the
// returned pixels. Latency from accepted start to the done pulse is
// always 17 cycles, whatever the mask.
module uss_gather (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] neighbor_sel,
    input  logic [2:0]  X_c,
    input  logic [2:0]  Y_c,
    input  logic [2:0]  X_in,
    output logic        rd_en,
    output logic [5:0]  rd_addr,
    output logic        busy,
    output logic        done,
    output logic [6:0]  sum,
    output logic [4:0]  cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  idx_reg;
    logic [15:0] mask_reg;
    logic [2:0]  xc_reg;
    logic [2:0]  yc_reg;
    logic        pend_reg;
    logic [6:0]  sum_reg;
    logic [4:0]  cnt_reg;

    logic        accept;
    logic [4:0]  win_x;
    logic [4:0]  win_y;
    logic [15:0] in_img;

    assign accept = (state_reg == IDLE) && start;

    // Per window position: does it land inside the 8x8 image? Coordinates
    // range -1..9, so the position is inside exactly when bits [4:3] are zero.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_in_img
            localparam logic [4:0] COL = 5'(gi % 4);
            localparam logic [4:0] ROW = 5'(gi / 4);
            logic [4:0] gx;
            logic [4:0] gy;
            assign gx = {2'b00, xc_reg} + COL - 5'd1;
            assign gy = {2'b00, yc_reg} + ROW - 5'd1;
            assign in_img[gi] = (gx[4:3] == 2'b00) && (gy[4:3] == 2'b00);
        end
    endgenerate

    // Coordinates of the window position currently examined, and the read strobe.
    always_comb begin
        win_x   = {2'b00, xc_reg} + {3'b000, idx_reg[1:0]} - 5'd1;
        win_y   = {2'b00, yc_reg} + {3'b000, idx_reg[3:2]} - 5'd1;
        rd_en   = (state_reg == SCAN) && mask_reg[idx_reg] && in_img[idx_reg];
        rd_addr = rd_en ? {win_y[2:0], win_x[2:0]} : 6'd0;
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (idx_reg == 4'd15) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture the job parameters on acceptance only; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_reg <= 16'd0;
            xc_reg   <= 3'd0;
            yc_reg   <= 3'd0;
        end else if (accept) begin
            mask_reg <= neighbor_sel;
            xc_reg   <= X_c;
            yc_reg   <= Y_c;
        end
    end

    // Window index: one mask bit per SCAN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg <= 4'd0;
        end else if (accept) begin
            idx_reg <= 4'd0;
        end else if (state_reg == SCAN) begin
            idx_reg <= idx_reg + 4'd1;
        end
    end

    // pend marks that the buffer is returning data this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg <= 1'b0;
        end else begin
            pend_reg <= rd_en;
        end
    end

    // Accumulate returned pixels; results hold until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg <= 7'd0;
            cnt_reg <= 5'd0;
        end else if (accept) begin
            sum_reg <= 7'd0;
            cnt_reg <= 5'd0;
        end else if (pend_reg) begin
            sum_reg <= sum_reg + {4'b0000, X_in};
            cnt_reg <= cnt_reg + 5'd1;
        end
    end

    assign sum = sum_reg;
    assign cnt = cnt_reg;

endmodule

// File: tb/tb_uss_gather.sv
// Bench for uss_gather: directed jobs with hand-computed read addresses and
// results queued by the stimulus, checked by an independent negedge monitor.
module tb_uss_gather;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] neighbor_sel;
    logic [2:0]  X_c;
    logic [2:0]  Y_c;
    logic [2:0]  X_in = 3'd0;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic        busy;
    logic        done;
    logic [6:0]  sum;
    logic [4:0]  cnt;

    uss_gather dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .neighbor_sel (neighbor_sel),
        .X_c          (X_c),
        .Y_c          (Y_c),
        .X_in         (X_in),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .busy         (busy),
        .done         (done),
        .sum          (sum),
        .cnt          (cnt)
    );

    always #5 clk = ~clk;

    // Count of rising edges seen so far; read only at negedges.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel buffer model: one-cycle registered read.
    logic [2:0] mem [64];
    always @(posedge clk) begin
        if (rd_en) X_in <= mem[rd_addr];
    end

    typedef struct {
        int          esum;
        int          ecnt;
        int unsigned done_cyc;
    } res_t;

    res_t exp_res[$];
    int   exp_addr[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    task automatic check(input string name, input int act, input int req);
        tests_run++;
        if (act != req) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic flag(input string name, input int act);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: got %0d, expected nothing (t=%0t)", name, act, $time);
    endtask

    // Monitor: compares every read and every done pulse against the queues.
    always @(negedge clk) begin
        if (rd_en) begin
            if (exp_addr.size() == 0) begin
                flag("unexpected_read", int'(rd_addr));
            end else begin
                int a;
                a = exp_addr.pop_front();
                check("rd_addr", int'(rd_addr), a);
                $display("[TB] read addr=%0d expected=%0d", rd_addr, a);
            end
        end else begin
            check("rd_addr_idle_zero", int'(rd_addr), 0);
        end
        if (done) begin
            if (exp_res.size() == 0) begin
                flag("unexpected_done", int'(cyc));
            end else begin
                res_t r;
                r = exp_res.pop_front();
                check("sum", int'(sum), r.esum);
                check("cnt", int'(cnt), r.ecnt);
                check("done_cycle", int'(cyc), int'(r.done_cyc));
                check("reads_missing", exp_addr.size(), 0);
                $display("[TB] done sum=%0d cnt=%0d (exp %0d/%0d)", sum, cnt, r.esum, r.ecnt);
            end
        end
    end

    // mode 0: (x+y)&7, mode 1: all 7, mode 2: x
    task automatic fill_mem(input int mode);
        for (int a = 0; a < 64; a++) begin
            int x;
            int y;
            x = a % 8;
            y = a / 8;
            case (mode)
                0:       mem[a] = 3'((x + y) & 7);
                1:       mem[a] = 3'd7;
                default: mem[a] = 3'(x);
            endcase
        end
    endtask

    // Issue one start pulse; scrambles the inputs right after acceptance.
    task automatic do_start(input logic [15:0] m, input logic [2:0] xc, input logic [2:0] yc,
                            output int unsigned t);
        @(negedge clk);
        neighbor_sel = m;
        X_c          = xc;
        Y_c          = yc;
        start        = 1'b1;
        t            = cyc + 1;
        @(negedge clk);
        start        = 1'b0;
        neighbor_sel = ~m;
        X_c          = xc + 3'd3;
        Y_c          = yc + 3'd5;
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic push_res(input int s, input int c, input int unsigned t);
        res_t r;
        r.esum     = s;
        r.ecnt     = c;
        r.done_cyc = t + 17;
        exp_res.push_back(r);
    endtask

    task automatic push_interior();
        for (int y = 2; y <= 5; y++)
            for (int x = 2; x <= 5; x++)
                exp_addr.push_back(y * 8 + x);
    endtask

    task automatic push_clipped();
        int a [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        for (int i = 0; i < 9; i++) exp_addr.push_back(a[i]);
    endtask

    // Run one full job whose expected reads were queued already.
    task automatic run_job(input logic [15:0] m, input logic [2:0] xc, input logic [2:0] yc,
                           input int s, input int c);
        int unsigned t;
        do_start(m, xc, yc, t);
        push_res(s, c, t);
        repeat (16) @(negedge clk);
        check("busy_before_done", int'(busy), 1);
        @(negedge clk);
        check("busy_during_done", int'(busy), 0);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        rst          = 1'b1;
        start        = 1'b0;
        neighbor_sel = 16'd0;
        X_c          = 3'd0;
        Y_c          = 3'd0;
        fill_mem(0);
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_rd_en", int'(rd_en), 0);
        check("reset_sum", int'(sum), 0);
        check("reset_cnt", int'(cnt), 0);
        rst = 1'b0;
        @(negedge clk);

        // Edge-clipped window at the origin.
        fill_mem(0);
        push_clipped();
        run_job(16'hFFFF, 3'd0, 3'd0, 18, 9);

        // Full interior window, maximum sum.
        fill_mem(1);
        push_interior();
        run_job(16'hFFFF, 3'd3, 3'd3, 112, 16);

        // Empty mask: no reads, same latency.
        run_job(16'h0000, 3'd4, 3'd4, 0, 0);

        // Diagonal mask past the bottom-right corner.
        fill_mem(2);
        exp_addr.push_back(54);
        exp_addr.push_back(63);
        run_job(16'h8421, 3'd7, 3'd7, 13, 2);

        // Second start while busy must be ignored.
        fill_mem(1);
        push_interior();
        do_start(16'hFFFF, 3'd3, 3'd3, t);
        push_res(112, 16, t);
        repeat (2) @(negedge clk);
        @(negedge clk);
        start        = 1'b1;
        neighbor_sel = 16'h0001;
        X_c          = 3'd0;
        Y_c          = 3'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        repeat (20) @(negedge clk);
        check("no_second_job_busy", int'(busy), 0);
        check("ignored_start_sum_held", int'(sum), 112);

        // Reset in the middle of a scan.
        fill_mem(1);
        exp_addr.push_back(18);
        exp_addr.push_back(19);
        exp_addr.push_back(20);
        exp_addr.push_back(21);
        exp_addr.push_back(26);
        exp_addr.push_back(27);
        exp_addr.push_back(28);
        do_start(16'hFFFF, 3'd3, 3'd3, t);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_busy", int'(busy), 0);
        check("midreset_rd_en", int'(rd_en), 0);
        check("midreset_sum", int'(sum), 0);
        check("midreset_cnt", int'(cnt), 0);
        $display("[TB] mid-scan reset busy=%0d sum=%0d cnt=%0d", busy, sum, cnt);
        repeat (25) @(negedge clk);
        check("midreset_still_idle", int'(busy), 0);

        // Fresh job after the reset completes normally.
        fill_mem(0);
        push_clipped();
        run_job(16'hFFFF, 3'd0, 3'd0, 18, 9);

        repeat (5) @(negedge clk);
        check("addr_queue_empty", exp_addr.size(), 0);
        check("res_queue_empty", exp_res.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uss_gather.md
# uss_gather

Consumer of the 16-bit neighbor-selection mask produced by the USS selector. On a start pulse it latches the mask and the centre coordinate. It then walks the 4x4 window bit by bit, issuing a pixel-memory read for each selected in-image neighbor, and accumulates the returned 3-bit pixel values into a sum and a count for the downstream averaging stage. It sits between the USS selector and the 8x8 pixel buffer, and owns the buffer's read port while busy.

## Interface
Parameters: none. Image size is fixed at 8x8, window 4x4, pixel width 3.

- clk  input  1  system clock; every register updates on its rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; accepted only in IDLE
- neighbor_sel  input  16  selection mask; bit k covers window row k/4, column k%4; sampled on the accepted start
- X_c  input  3  centre x; sampled on the accepted start
- Y_c  input  3  centre y; sampled on the accepted start
- X_in  input  3  pixel data from the buffer; valid the cycle after rd_en
- rd_en  output  1  read strobe to the pixel buffer
- rd_addr  output  6  read address {y[2:0], x[2:0]}
- busy  output  1  high in SCAN and DRAIN
- done  output  1  one-cycle completion pulse
- sum  output  7  accumulated pixel sum (max 16*7 = 112)
- cnt  output  5  number of pixels read (0..16)

## Operation
States: IDLE, SCAN, DRAIN, DONE.

- **IDLE**
  - When start=1, latch neighbor_sel, X_c and Y_c.
  - Clear sum, cnt and idx, then go to SCAN.
  - When start=0, stay in IDLE.
- **SCAN**
  - idx runs 0..15, one bit per cycle.
  - Window coordinate: x = X_c + (idx%4) - 1, y = Y_c + (idx/4) - 1. Compute both in signed 5 bits.
  - rd_en = mask[idx] && 0<=x<=7 && 0<=y<=7. Out-of-image bits are skipped silently.
  - rd_en and rd_addr are combinational from registered state, idx and latched coordinates.
  - rd_addr = {y[2:0], x[2:0]} when rd_en=1, and 0 otherwise.
  - When idx=15, go to DRAIN.
- **Accumulate**
  - Keep a registered copy of rd_en (pend).
  - On every edge where pend=1: sum += X_in (zero-extended), cnt += 1.
  - Neither sum nor cnt can overflow at its stated width.
- **DRAIN**
  - One cycle with no read; it completes the final pending accumulate.
  - Then go to DONE.
- **DONE**
  - done=1 for exactly one cycle, then go to IDLE.
- **Result hold:** sum and cnt keep their values until the next accepted start or rst.
- **start outside IDLE:** start in SCAN, DRAIN or DONE is ignored. No queuing, and no change to the latched inputs.
- **Input changes mid-scan:** changes on neighbor_sel, X_c or Y_c after acceptance have no effect.
- **Reset:** rst=1 forces IDLE and zeroes idx, pend, sum and cnt. rd_en, busy and done all read 0. rst overrides start in the same cycle.
- **Reset mid-operation:** the scan is abandoned. No done pulse is produced and no partial result is kept.

## Timing
Let start be accepted at edge T.

- Cycle k (between edges T+k and T+k+1), for k=0..15, examines idx=k and may assert rd_en.
- The buffer returns X_in in cycle k+1. It is accumulated at edge T+k+2.
- State is DRAIN from edge T+16 and DONE from edge T+17. done is high from T+17 to T+18, and sum/cnt are final during that cycle.
- busy is high from T to T+17. IDLE resumes at T+18, and a new start is accepted at edge T+18 at the earliest.
- Latency is fixed at 17 cycles from acceptance to done, independent of the mask. An all-zero mask still takes the full 17 cycles.
- Throughput is one job per 18 cycles.

## Test plan
- **Edge-clipped window:** X_c=0, Y_c=0, mask=0xFFFF, memory pixel = (x+y)&7.
  - Exactly 9 rd_en pulses, addresses {0,1,2,8,9,10,16,17,18}.
  - done at T+17; sum=18, cnt=9.
- **Full interior window:** X_c=3, Y_c=3, mask=0xFFFF, memory all 7.
  - 16 reads, x and y in 2..5.
  - sum=112, cnt=16, no overflow.
- **Empty mask:** mask=0x0000.
  - rd_en never asserted.
  - done still at T+17; sum=0, cnt=0.
- **Diagonal mask past the corner:** X_c=7, Y_c=7, mask=0x8421, memory pixel = x.
  - Reads only at rd_addr=54 (idx0) and 63 (idx5); bits 10 and 15 are skipped.
  - sum=13, cnt=2.
- **start ignored while busy:** repeat a start pulse at T+3 with a different mask.
  - No effect on the first job, and no second job starts.
- **Reset mid-scan:** assert rst for 1 cycle at T+6.
  - Next cycle: busy=0, rd_en=0, sum=0, cnt=0.
  - No done pulse.
  - A fresh start afterwards completes normally at its own T'+17.
